// File: rtl/pmem_port_arbiter_if.sv
// pmem_port_arbiter_if: request, response and memory-side signals of the program memory arbiter.
interface pmem_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic              a_read;
    logic [ADDR_W-1:0] a_address;
    logic              a_waitrequest;
    logic [DATA_W-1:0] a_readdata;
    logic              a_readdatavalid;
    logic              b_read;
    logic              b_write;
    logic [ADDR_W-1:0] b_address;
    logic [BE_W-1:0]   b_byteenable;
    logic [DATA_W-1:0] b_writedata;
    logic              b_waitrequest;
    logic [DATA_W-1:0] b_readdata;
    logic              b_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    modport master (
        output a_read, a_address, b_read, b_write, b_address, b_byteenable, b_writedata, mem_readdata,
        input  a_waitrequest, a_readdata, a_readdatavalid, b_waitrequest, b_readdata, b_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
    modport slave (
        input  a_read, a_address, b_read, b_write, b_address, b_byteenable, b_writedata, mem_readdata,
        output a_waitrequest, a_readdata, a_readdatavalid, b_waitrequest, b_readdata, b_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/pmem_port_arbiter.sv
// pmem_port_arbiter: two-master arbiter for the single-port program memory, one grant per cycle.
// Define PMEM_ARB_RR_EN for round-robin contention; default is fixed A > B with starvation override.
module pmem_port_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset_n,
    input logic               freeze,
    pmem_port_arbiter_if.slave bus
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic              active, req_a, req_b, pick_b, grant_a, grant_b, b_wr;
    logic [7:0]        cnt_a, cnt_b;
    logic              tag_v, tag_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] q;

    function automatic logic [7:0] next_cnt(input logic req, input logic gnt, input logic act, input logic [7:0] c);
        return (!req || gnt) ? 8'd0 : (act && c < LIMIT) ? c + 8'd1 : c;
    endfunction

`ifdef PMEM_ARB_RR_EN
    logic rr_b;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rr_b <= 1'b0;
        else if (active && req_a && req_b) rr_b <= grant_a;
    // pick_b names the winner of a contended cycle; the starved loser always overrides
    always_comb pick_b = rr_b ? (cnt_a < LIMIT) : (cnt_b >= LIMIT);
`else
    always_comb pick_b = cnt_b >= LIMIT;
`endif

    always_comb begin
        active   = reset_n & ~freeze;
        req_a    = bus.a_read;
        req_b    = bus.b_read | bus.b_write;
        grant_a  = active & req_a & ~(req_b & pick_b);
        grant_b  = active & req_b & ~(req_a & ~pick_b);
        b_wr     = grant_b & bus.b_write;
        sel_addr = grant_b ? bus.b_address : bus.a_address;
        sel_be   = b_wr ? bus.b_byteenable : {BE_W{1'b1}};
        q        = bus.mem_readdata;
    end

    assign bus.a_waitrequest   = ~active | (req_a & ~grant_a);
    assign bus.b_waitrequest   = ~active | (req_b & ~grant_b);
    assign bus.a_readdata      = q;
    assign bus.b_readdata      = q;
    assign bus.a_readdatavalid = tag_v & ~tag_b;
    assign bus.b_readdatavalid = tag_v & tag_b;
    assign bus.mem_address     = sel_addr;
    assign bus.mem_byteenable  = sel_be;
    assign bus.mem_chipselect  = grant_a | grant_b;
    assign bus.mem_write       = b_wr;
    assign bus.mem_writedata   = bus.b_writedata;
    assign bus.mem_clken       = ~freeze;

    // a read+write on B counts as a write, so it never tags a return
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            tag_v <= 1'b0;
            tag_b <= 1'b0;
            cnt_a <= 8'd0;
            cnt_b <= 8'd0;
        end else begin
            tag_v <= grant_a | (grant_b & bus.b_read & ~bus.b_write);
            tag_b <= grant_b;
            cnt_a <= next_cnt(req_a, grant_a, active, cnt_a);
            cnt_b <= next_cnt(req_b, grant_b, active, cnt_b);
        end
endmodule

// File: tb/tb_pmem_port_arbiter.sv
// tb_pmem_port_arbiter: directed plus random stimulus against a behavioural arbiter and memory model.
module tb_pmem_port_arbiter;
    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int LIM = 8;
`ifdef PMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic freeze;
    always #5 clk = ~clk;

    pmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) bus();
    pmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze), .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = nw[8*i +: 8];
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory device: synchronous q, writes and q updates only while clocked
    logic [31:0] mem [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic [31:0] q;
    assign bus.mem_readdata = q;
    always @(posedge clk)
        if (bus.mem_clken) begin
            if (bus.mem_chipselect && bus.mem_write)
                mem[bus.mem_address] <= merge(mem[bus.mem_address], bus.mem_writedata, bus.mem_byteenable);
            q <= mem[bus.mem_address];
        end

    // reference model: denial counts, last contended winner, one pending read
    int          ca, cb;
    bit          fav_b, pv, pown;
    logic [31:0] pdata;

    always @(negedge clk) begin
        bit ra, rb, ga, gb, bw, def_b;
        if (!reset_n) begin
            chk("rst_a_wait", bus.a_waitrequest, 1);
            chk("rst_b_wait", bus.b_waitrequest, 1);
            chk("rst_cs", bus.mem_chipselect, 0);
            chk("rst_write", bus.mem_write, 0);
            chk("rst_a_valid", bus.a_readdatavalid, 0);
            chk("rst_b_valid", bus.b_readdatavalid, 0);
            ca = 0; cb = 0; fav_b = 0; pv = 0;
        end else begin
            ra = bus.a_read;
            rb = bus.b_read || bus.b_write;
            bw = bus.b_write;
            ga = 0; gb = 0;
            if (!freeze) begin
                if (ra && rb) begin
                    def_b = RR ? fav_b : 1'b0;
                    gb = def_b ? !(ca >= LIM) : (cb >= LIM);
                    ga = !gb;
                end else begin
                    ga = ra;
                    gb = rb;
                end
            end
            chk("a_wait", bus.a_waitrequest, freeze ? 1 : (ra && !ga));
            chk("b_wait", bus.b_waitrequest, freeze ? 1 : (rb && !gb));
            chk("mem_clken", bus.mem_clken, !freeze);
            chk("mem_cs", bus.mem_chipselect, ga || gb);
            chk("mem_write", bus.mem_write, gb && bw);
            if (ga || gb) begin
                chk("mem_addr", bus.mem_address, gb ? bus.b_address : bus.a_address);
                chk("mem_be", bus.mem_byteenable, (gb && bw) ? bus.b_byteenable : 4'hF);
            end
            if (gb && bw) chk("mem_wdata", bus.mem_writedata, bus.b_writedata);
            chk("a_valid", bus.a_readdatavalid, pv && !pown);
            chk("b_valid", bus.b_readdatavalid, pv && pown);
            if (pv) begin
                chk("a_rdata", bus.a_readdata, pdata);
                chk("b_rdata", bus.b_readdata, pdata);
            end
            pv = ga || (gb && bus.b_read && !bw);
            pown = gb;
            if (pv) pdata = ref_mem[gb ? bus.b_address : bus.a_address];
            if (gb && bw) ref_mem[bus.b_address] = merge(ref_mem[bus.b_address], bus.b_writedata, bus.b_byteenable);
            ca = (!ra || ga) ? 0 : (!freeze && ca < LIM) ? ca + 1 : ca;
            cb = (!rb || gb) ? 0 : (!freeze && cb < LIM) ? cb + 1 : cb;
            if (!freeze && ra && rb) fav_b = ga;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] rand_addr();
        return $urandom_range(0, 1) ? 15'($urandom_range(0, 15)) : 15'(15'h7FF0 + $urandom_range(0, 15));
    endfunction

    initial begin
        bit a_acc, b_acc, exp_b;
        reset_n = 1'b0; freeze = 1'b0;
        bus.a_read = 0; bus.a_address = '0;
        bus.b_read = 0; bus.b_write = 0; bus.b_address = '0; bus.b_byteenable = '0; bus.b_writedata = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 32'(i) * 32'h9E3779B1;
            ref_mem[i] = mem[i];
        end
        mem[16'h0010] = 32'hDEADBEEF; ref_mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h7FFF] = 32'hAABBCCDD; ref_mem[16'h7FFF] = 32'hAABBCCDD;
        tick(); tick();
        @(negedge clk);
        chk("reset_a_valid_lit", bus.a_readdatavalid, 0);
        tick(); reset_n = 1'b1;
        tick();

        // A read of 0x0010
        bus.a_read = 1; bus.a_address = 15'h0010;
        @(negedge clk); chk("a_rd_wait_lit", bus.a_waitrequest, 0);
        tick(); bus.a_read = 0;
        @(negedge clk);
        chk("a_rd_valid_lit", bus.a_readdatavalid, 1);
        chk("a_rd_data_lit", bus.a_readdata, 32'hDEADBEEF);
        chk("a_rd_bvalid_lit", bus.b_readdatavalid, 0);

        // B partial write then read back
        tick();
        bus.b_write = 1; bus.b_address = 15'h7FFF; bus.b_byteenable = 4'b0011; bus.b_writedata = 32'h12345678;
        @(negedge clk); chk("b_wr_wait_lit", bus.b_waitrequest, 0);
        tick(); bus.b_write = 0; bus.b_read = 1;
        tick(); bus.b_read = 0;
        @(negedge clk);
        chk("b_rd_valid_lit", bus.b_readdatavalid, 1);
        chk("b_rd_data_lit", bus.b_readdata, 32'hAABB5678);

        // sustained contention
        tick(); tick();
        bus.a_read = 1; bus.a_address = 15'h0001; bus.b_read = 1; bus.b_address = 15'h0002;
        for (int i = 0; i < 18; i++) begin
            exp_b = RR ? (i % 2 == 1) : (i % 9 == 8);
            @(negedge clk);
            chk($sformatf("contend_b_%0d", i), !bus.b_waitrequest, exp_b);
            chk($sformatf("contend_a_%0d", i), !bus.a_waitrequest, !exp_b);
            tick();
        end
        bus.a_read = 0; bus.b_read = 0;
        tick(); tick();

        // read grant followed by four frozen cycles
        bus.a_read = 1; bus.a_address = 15'h0010;
        @(negedge clk); chk("frz_grant_lit", bus.a_waitrequest, 0);
        tick(); freeze = 1; bus.a_address = 15'h0003; bus.b_read = 1; bus.b_address = 15'h7FFF;
        @(negedge clk);
        chk("frz_valid_lit", bus.a_readdatavalid, 1);
        chk("frz_data_lit", bus.a_readdata, 32'hDEADBEEF);
        chk("frz_clken_lit", bus.mem_clken, 0);
        chk("frz_cs_lit", bus.mem_chipselect, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("frz_hold_cs_lit", bus.mem_chipselect, 0);
            chk("frz_hold_await_lit", bus.a_waitrequest, 1);
        end
        tick(); freeze = 0;
        @(negedge clk);
        chk("unfrz_cs_lit", bus.mem_chipselect, 1);
        chk("unfrz_a_lit", bus.a_waitrequest, 0);
        tick(); bus.a_read = 0;
        @(negedge clk); chk("unfrz_b_lit", bus.b_waitrequest, 0);
        tick(); bus.b_read = 0;

        // reset while a B read is in flight
        tick();
        bus.b_read = 1; bus.b_address = 15'h0010;
        @(negedge clk); chk("rst_fl_grant_lit", bus.b_waitrequest, 0);
        tick(); bus.b_read = 0; reset_n = 0;
        @(negedge clk); chk("rst_fl_bvalid_lit", bus.b_readdatavalid, 0);
        tick(); tick(); reset_n = 1;
        tick();
        bus.a_read = 1; bus.a_address = 15'h0010;
        @(negedge clk); chk("post_rst_grant_lit", bus.a_waitrequest, 0);
        tick(); bus.a_read = 0;
        @(negedge clk); chk("post_rst_data_lit", bus.a_readdata, 32'hDEADBEEF);

        // read+write together acts as a write
        tick();
        bus.b_read = 1; bus.b_write = 1; bus.b_address = 15'h0005; bus.b_byteenable = 4'hF; bus.b_writedata = 32'hCAFEF00D;
        @(negedge clk); chk("rw_grant_lit", bus.b_waitrequest, 0);
        tick(); bus.b_write = 0;
        @(negedge clk); chk("rw_no_valid_lit", bus.b_readdatavalid, 0);
        tick(); bus.b_read = 0;
        @(negedge clk);
        chk("rw_readback_valid_lit", bus.b_readdatavalid, 1);
        chk("rw_readback_lit", bus.b_readdata, 32'hCAFEF00D);

        // random traffic, requests held until accepted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            a_acc = bus.a_read && !bus.a_waitrequest;
            b_acc = (bus.b_read || bus.b_write) && !bus.b_waitrequest;
            tick();
            freeze = ($urandom_range(0, 9) == 0);
            reset_n = ($urandom_range(0, 199) != 0);
            if (!bus.a_read || a_acc) begin
                bus.a_read = $urandom_range(0, 2) != 0;
                bus.a_address = rand_addr();
            end
            if (!(bus.b_read || bus.b_write) || b_acc) begin
                case ($urandom_range(0, 5))
                    0, 1: begin bus.b_read = 1; bus.b_write = 0; end
                    2, 3: begin bus.b_read = 0; bus.b_write = 1; end
                    4: begin bus.b_read = 1; bus.b_write = 1; end
                    default: begin bus.b_read = 0; bus.b_write = 0; end
                endcase
                bus.b_address = rand_addr();
                bus.b_byteenable = 4'($urandom_range(0, 15));
                bus.b_writedata = $urandom;
            end
        end
        tick();
        reset_n = 1; freeze = 0; bus.a_read = 0; bus.b_read = 0; bus.b_write = 0;
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
